// File: rtl/pdec_pkg.sv
// Shared types and helpers for the registered 4-to-16 one-hot decoder.
// Holds the state encoding, the address/word widths and the one-hot decode.
package pdec_pkg;

   localparam int ADDR_W   = 4;
   localparam int ONEHOT_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_t;

   function automatic logic [ONEHOT_W-1:0] decode(input logic [ADDR_W-1:0] addr);
      logic [ONEHOT_W-1:0] one;
      one    = {{(ONEHOT_W-1){1'b0}}, 1'b1};
      decode = one << addr;
   endfunction

endpackage

// File: rtl/pdec_skid.sv
// One-entry valid/data holding register for a transfer that arrives while the
// decoder is still busy; clr drops the entry, and a load wins over an unload.
module pdec_skid #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         unload,
   output logic         valid,
   output logic [W-1:0] data
);

   logic         valid_r;
   logic [W-1:0] data_r;

   // Entry storage: flush, refill, or drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= 1'b0;
         data_r  <= {W{1'b0}};
      end else if (clr) begin
         valid_r <= 1'b0;
      end else if (load) begin
         valid_r <= 1'b1;
         data_r  <= load_data;
      end else if (unload) begin
         valid_r <= 1'b0;
      end
   end

   assign valid = valid_r;
   assign data  = data_r;

endmodule

// File: rtl/priority_decoder.sv
// Registered 4-to-16 one-hot decoder: drives 1<<addr on {A,B} for HOLD_CYCLES,
// then GAP_CYCLES of zeros. Define PDEC_SKID_EN to add a one-entry pending buffer.
module priority_decoder
   import pdec_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [7:0]        A,
   output logic [7:0]        B,
   output logic              out_valid,
   output logic              busy
);

   localparam int MAX_CYC   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W     = $clog2(MAX_CYC + 1);
   localparam int HOLD_LD_I = HOLD_CYCLES - 1;
   localparam int GAP_LD_I  = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
   localparam logic [CNT_W-1:0] HOLD_LD  = HOLD_LD_I[CNT_W-1:0];
   localparam logic [CNT_W-1:0] GAP_LD   = GAP_LD_I[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam bit               GAP_EN   = (GAP_CYCLES > 0);

   state_t              state_r, state_s;
   logic [CNT_W-1:0]    cnt_r, cnt_s;
   logic [ADDR_W-1:0]   addr_r, addr_s;
   logic [ONEHOT_W-1:0] word_r;
   logic                out_valid_r;
   logic                busy_r;
   logic                in_ready_s;
   logic                take_s;
   logic                finish_s;
   logic                pend_valid_s;
   logic [ADDR_W-1:0]   pend_addr_s;

`ifdef PDEC_SKID_EN
   logic pend_load_s;
   logic pend_unload_s;

   assign in_ready_s = ((state_r == IDLE) || !pend_valid_s) && !clr;

   // A busy-time transfer is parked unless it can start directly on the final cycle.
   assign pend_load_s   = take_s && (state_r != IDLE) && !(finish_s && !pend_valid_s);
   assign pend_unload_s = finish_s && pend_valid_s;

   pdec_skid #(
      .W(ADDR_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .load      (pend_load_s),
      .load_data (in_addr),
      .unload    (pend_unload_s),
      .valid     (pend_valid_s),
      .data      (pend_addr_s)
   );
`else
   assign in_ready_s   = (state_r == IDLE) && !clr;
   assign pend_valid_s = 1'b0;
   assign pend_addr_s  = {ADDR_W{1'b0}};
`endif

   assign take_s   = in_valid && in_ready_s;
   assign finish_s = (cnt_r == CNT_ZERO) &&
                     ((state_r == GAP) || ((state_r == DRIVE) && !GAP_EN));

   // Next-state, counter and latched-address selection.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      addr_s  = addr_r;
      if (clr) begin
         state_s = IDLE;
         cnt_s   = CNT_ZERO;
      end else if (finish_s) begin
         if (pend_valid_s) begin
            state_s = DRIVE;
            cnt_s   = HOLD_LD;
            addr_s  = pend_addr_s;
         end else if (take_s) begin
            state_s = DRIVE;
            cnt_s   = HOLD_LD;
            addr_s  = in_addr;
         end else begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
         end
      end else begin
         case (state_r)
            IDLE: begin
               if (take_s) begin
                  state_s = DRIVE;
                  cnt_s   = HOLD_LD;
                  addr_s  = in_addr;
               end else begin
                  cnt_s = CNT_ZERO;
               end
            end
            DRIVE: begin
               if (cnt_r != CNT_ZERO) begin
                  cnt_s = cnt_r - CNT_ONE;
               end else begin
                  state_s = GAP;
                  cnt_s   = GAP_LD;
               end
            end
            GAP: begin
               cnt_s = cnt_r - CNT_ONE;
            end
            default: begin
               state_s = IDLE;
               cnt_s   = CNT_ZERO;
            end
         endcase
      end
   end

   // State registers plus outputs registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         cnt_r       <= CNT_ZERO;
         addr_r      <= {ADDR_W{1'b0}};
         word_r      <= {ONEHOT_W{1'b0}};
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         addr_r      <= addr_s;
         word_r      <= (state_s == DRIVE) ? decode(addr_s) : {ONEHOT_W{1'b0}};
         out_valid_r <= (state_s == DRIVE);
         busy_r      <= (state_s != IDLE);
      end
   end

   assign in_ready  = in_ready_s;
   assign A         = word_r[15:8];
   assign B         = word_r[7:0];
   assign out_valid = out_valid_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_priority_decoder.sv
// Self-checking bench for priority_decoder: vector tables, directed corner
// sequences and a randomized run against a timestamp-based reference model.
module tb_priority_decoder;

   localparam int H  = 4;
   localparam int G  = 1;
   localparam int H0 = 2;
`ifdef PDEC_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0, in_valid = 1'b0;
   logic [3:0] in_addr = 4'd0;
   logic       in_ready, out_valid, busy;
   logic [7:0] A, B;
   logic       clr0 = 1'b0, in_valid0 = 1'b0;
   logic [3:0] in_addr0 = 4'd0;
   logic       in_ready0, out_valid0, busy0;
   logic [7:0] A0, B0;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   priority_decoder #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) u_dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_addr(in_addr), .in_valid(in_valid),
      .in_ready(in_ready), .A(A), .B(B), .out_valid(out_valid), .busy(busy));

   priority_decoder #(.HOLD_CYCLES(H0), .GAP_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .clr(clr0), .in_addr(in_addr0), .in_valid(in_valid0),
      .in_ready(in_ready0), .A(A0), .B(B0), .out_valid(out_valid0), .busy(busy0));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference model: each accepted transfer becomes a time window measured in edges.
   int         m_now, m_free, m_dstart, m_dend;
   logic [3:0] m_addr, m_paddr;
   bit         m_pv;

   task automatic model_reset();
      m_now = 0; m_free = 0; m_dstart = 0; m_dend = 0;
      m_addr = 4'd0; m_paddr = 4'd0; m_pv = 1'b0;
   endtask

   function automatic bit m_ready();
      bit idle;
      idle = (m_now >= m_free);
      if (SKID) m_ready = (idle || !m_pv) && !clr;
      else      m_ready = idle && !clr;
   endfunction

   function automatic logic [15:0] m_word();
      logic [15:0] one;
      one = 16'd1;
      m_word = (m_now >= m_dstart && m_now < m_dend) ? (one << m_addr) : 16'd0;
   endfunction

   task automatic m_start(input logic [3:0] a, input int e);
      m_addr = a; m_dstart = e; m_dend = e + H; m_free = e + H + G;
   endtask

   task automatic model_edge(input bit acc);
      int e;
      bit idle_prev, ends_now;
      e = m_now + 1;
      idle_prev = (m_now >= m_free);
      ends_now  = (m_free == e);
      if (clr) begin
         m_free = e;
         if (m_dend > e) m_dend = e;
         m_pv = 1'b0;
      end else if (ends_now && m_pv) begin
         m_start(m_paddr, e);
         m_pv = 1'b0;
         if (acc) begin m_pv = 1'b1; m_paddr = in_addr; end
      end else if (acc && (idle_prev || ends_now)) begin
         m_start(in_addr, e);
      end else if (acc) begin
         m_pv = 1'b1; m_paddr = in_addr;
      end
      m_now = e;
   endtask

   task automatic cycle_model(input string nm);
      bit r;
      #1;
      r = m_ready();
      chk({nm, " in_ready"}, {31'd0, in_ready}, {31'd0, r});
      @(posedge clk);
      model_edge(in_valid && r);
      #1;
      chk({nm, " word"}, {16'd0, A, B}, {16'd0, m_word()});
      chk({nm, " out_valid"}, {31'd0, out_valid}, {31'd0, (m_word() != 16'd0)});
      chk({nm, " busy"}, {31'd0, busy}, {31'd0, (m_now < m_free)});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; clr0 = 1'b0; in_valid0 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   typedef struct {
      logic        v;
      logic        c;
      logic [3:0]  a;
      logic        rdy;
      logic [15:0] w;
      logic        ov;
      logic        bsy;
   } vec_t;

   typedef struct {
      logic        v;
      logic [3:0]  a;
      logic        rdy;
      logic [15:0] w;
   } vec0_t;

   vec_t  tv[23];
   vec0_t tv0[6];

   initial begin
      logic [15:0] one, exp_w;
      // Main table: addr 9, addr 14 with in_addr wiggle, clr in 2nd DRIVE cycle, addr 15, clr in IDLE.
      tv[0]  = '{1'b1, 1'b0, 4'd9,  1'b1, 16'h0200, 1'b1, 1'b1};
      tv[1]  = '{1'b0, 1'b0, 4'd9,  SKID, 16'h0200, 1'b1, 1'b1};
      tv[2]  = '{1'b0, 1'b0, 4'd9,  SKID, 16'h0200, 1'b1, 1'b1};
      tv[3]  = '{1'b0, 1'b0, 4'd9,  SKID, 16'h0200, 1'b1, 1'b1};
      tv[4]  = '{1'b0, 1'b0, 4'd9,  SKID, 16'h0000, 1'b0, 1'b1};
      tv[5]  = '{1'b0, 1'b0, 4'd9,  SKID, 16'h0000, 1'b0, 1'b0};
      tv[6]  = '{1'b1, 1'b0, 4'd14, 1'b1, 16'h4000, 1'b1, 1'b1};
      tv[7]  = '{1'b0, 1'b0, 4'd1,  SKID, 16'h4000, 1'b1, 1'b1};
      tv[8]  = '{1'b0, 1'b0, 4'd1,  SKID, 16'h4000, 1'b1, 1'b1};
      tv[9]  = '{1'b0, 1'b0, 4'd1,  SKID, 16'h4000, 1'b1, 1'b1};
      tv[10] = '{1'b0, 1'b0, 4'd1,  SKID, 16'h0000, 1'b0, 1'b1};
      tv[11] = '{1'b0, 1'b0, 4'd1,  SKID, 16'h0000, 1'b0, 1'b0};
      tv[12] = '{1'b1, 1'b0, 4'd0,  1'b1, 16'h0001, 1'b1, 1'b1};
      tv[13] = '{1'b1, 1'b0, 4'd6,  SKID, 16'h0001, 1'b1, 1'b1};
      tv[14] = '{1'b1, 1'b1, 4'd3,  1'b0, 16'h0000, 1'b0, 1'b0};
      tv[15] = '{1'b1, 1'b0, 4'd15, 1'b1, 16'h8000, 1'b1, 1'b1};
      tv[16] = '{1'b0, 1'b0, 4'd15, SKID, 16'h8000, 1'b1, 1'b1};
      tv[17] = '{1'b0, 1'b0, 4'd15, SKID, 16'h8000, 1'b1, 1'b1};
      tv[18] = '{1'b0, 1'b0, 4'd15, SKID, 16'h8000, 1'b1, 1'b1};
      tv[19] = '{1'b0, 1'b0, 4'd15, SKID, 16'h0000, 1'b0, 1'b1};
      tv[20] = '{1'b0, 1'b0, 4'd15, SKID, 16'h0000, 1'b0, 1'b0};
      tv[21] = '{1'b1, 1'b1, 4'd7,  1'b0, 16'h0000, 1'b0, 1'b0};
      tv[22] = '{1'b0, 1'b0, 4'd7,  1'b1, 16'h0000, 1'b0, 1'b0};
`ifdef PDEC_SKID_EN
      // GAP=0, HOLD=2: addr 3 then 12 back to back, the second one parked.
      tv0[0] = '{1'b1, 4'd3,  1'b1, 16'h0008};
      tv0[1] = '{1'b1, 4'd12, 1'b1, 16'h0008};
      tv0[2] = '{1'b0, 4'd12, 1'b0, 16'h1000};
      tv0[3] = '{1'b0, 4'd12, 1'b1, 16'h1000};
      tv0[4] = '{1'b0, 4'd12, 1'b1, 16'h0000};
      tv0[5] = '{1'b0, 4'd12, 1'b1, 16'h0000};
`else
      // GAP=0, HOLD=2: in_valid held, one IDLE cycle between the pulses.
      tv0[0] = '{1'b1, 4'd3,  1'b1, 16'h0008};
      tv0[1] = '{1'b1, 4'd12, 1'b0, 16'h0008};
      tv0[2] = '{1'b1, 4'd12, 1'b0, 16'h0000};
      tv0[3] = '{1'b1, 4'd12, 1'b1, 16'h1000};
      tv0[4] = '{1'b0, 4'd12, 1'b0, 16'h1000};
      tv0[5] = '{1'b0, 4'd12, 1'b0, 16'h0000};
`endif

      @(negedge clk);
      rst_n = 1'b0;
      #2;
      chk("reset word", {16'd0, A, B}, 32'd0);
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset busy", {31'd0, busy}, 32'd0);
      do_reset();
      #1;
      chk("ready after reset", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 23; i++) begin
         in_valid = tv[i].v; clr = tv[i].c; in_addr = tv[i].a;
         #1;
         chk($sformatf("tbl%0d in_ready", i), {31'd0, in_ready}, {31'd0, tv[i].rdy});
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d word", i), {16'd0, A, B}, {16'd0, tv[i].w});
         chk($sformatf("tbl%0d out_valid", i), {31'd0, out_valid}, {31'd0, tv[i].ov});
         chk($sformatf("tbl%0d busy", i), {31'd0, busy}, {31'd0, tv[i].bsy});
      end
      in_valid = 1'b0; clr = 1'b0;

      one = 16'd1;
      for (int a = 0; a < 16; a++) begin
         in_valid = 1'b1; in_addr = a[3:0];
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         exp_w = one << a;
         chk($sformatf("sweep%0d word", a), {16'd0, A, B}, {16'd0, exp_w});
         if (a == 0)  chk("sweep addr0 B", {24'd0, B}, 32'h01);
         if (a == 15) chk("sweep addr15 A", {24'd0, A}, 32'h80);
         repeat (5) @(posedge clk);
         #1;
      end

      for (int i = 0; i < 6; i++) begin
         in_valid0 = tv0[i].v; in_addr0 = tv0[i].a;
         #1;
         chk($sformatf("gap0 %0d in_ready", i), {31'd0, in_ready0}, {31'd0, tv0[i].rdy});
         @(posedge clk);
         #1;
         chk($sformatf("gap0 %0d word", i), {16'd0, A0, B0}, {16'd0, tv0[i].w});
      end
      in_valid0 = 1'b0;

      // Asynchronous reset in the middle of a DRIVE for addr 5.
      do_reset();
      in_valid = 1'b1; in_addr = 4'd5;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("mid drive word", {16'd0, A, B}, 32'h0020);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async reset word", {16'd0, A, B}, 32'd0);
      chk("async reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("async reset busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      #1;
      chk("ready after async reset", {31'd0, in_ready}, 32'd1);

      do_reset();
      for (int i = 0; i < 600; i++) begin
         in_valid = ($urandom_range(0, 2) != 0);
         in_addr  = 4'($urandom_range(0, 15));
         clr      = ($urandom_range(0, 19) == 0);
         cycle_model($sformatf("rnd%0d", i));
      end
      in_valid = 1'b0; clr = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
